// File: rtl/ibex_fetch_realign_pkg.sv
// rtl/ibex_fetch_realign_pkg.sv - shared constants for the fetch realigner
package ibex_fetch_realign_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned HALF_W  = 16;
  // Wide enough for the largest legal buffer depth (4)
  localparam int unsigned CNT_W   = 3;

  localparam logic [1:0]         UNCOMP_OPC = 2'b11;
  localparam logic [INSTR_W-1:0] STEP_C     = 32'd2;
  localparam logic [INSTR_W-1:0] STEP_U     = 32'd4;

endpackage

// File: rtl/ibex_fetch_realign.sv
// rtl/ibex_fetch_realign.sv - word FIFO that realigns mixed 16/32-bit instructions
module ibex_fetch_realign
  import ibex_fetch_realign_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic [INSTR_W-1:0] clear_addr_i,
  input  logic               in_valid_i,
  input  logic [INSTR_W-1:0] in_rdata_i,
  input  logic               in_err_i,
  output logic               in_ready_o,
  output logic               out_valid_o,
  output logic [INSTR_W-1:0] out_instr_o,
  output logic [INSTR_W-1:0] out_addr_o,
  output logic               out_err_o,
  input  logic               out_ready_i
);

  logic [INSTR_W-1:0] word_q [DEPTH];
  logic [INSTR_W-1:0] word_d [DEPTH];
  logic [DEPTH-1:0]   err_q;
  logic [DEPTH-1:0]   err_d;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic [CNT_W-1:0]   wr_idx;
  logic [INSTR_W-1:0] addr_q;
  logic [INSTR_W-1:0] addr_d;

  logic               e0_valid;
  logic               e1_valid;
  logic               unaligned;
  logic [HALF_W-1:0]  e0_lo;
  logic [HALF_W-1:0]  e0_hi;
  logic [HALF_W-1:0]  e1_lo;
  logic [HALF_W-1:0]  first_half;
  logic               instr_compressed;
  logic               fire;
  logic               push;
  logic               pop;

  assign e0_valid   = (count_q != '0);
  assign e1_valid   = (count_q > CNT_W'(1));
  assign unaligned  = addr_q[1];
  assign e0_lo      = word_q[0][HALF_W-1:0];
  assign e0_hi      = word_q[0][INSTR_W-1:HALF_W];
  assign e1_lo      = word_q[1][HALF_W-1:0];
  assign first_half = unaligned ? e0_hi : e0_lo;
  assign instr_compressed = (first_half[1:0] != UNCOMP_OPC);

  assign in_ready_o = (count_q < CNT_W'(DEPTH)) & ~clear_i;
  assign out_addr_o = addr_q;

  always_comb begin
    out_instr_o = word_q[0];
    out_valid_o = e0_valid;
    out_err_o   = e0_valid & err_q[0];
    if (unaligned) begin
      if (instr_compressed) begin
        out_instr_o = {{HALF_W{1'b0}}, e0_hi};
      end else begin
        // Spanning instruction: an error in the lower half alone is enough to release it
        out_instr_o = {e1_lo, e0_hi};
        out_valid_o = e1_valid | (e0_valid & err_q[0]);
        out_err_o   = (e0_valid & err_q[0]) | (e1_valid & err_q[1]);
      end
    end
  end

  assign fire = out_valid_o & out_ready_i & ~clear_i;
  assign pop  = fire & (unaligned | ~instr_compressed);
  assign push = in_valid_i & in_ready_o;

  always_comb begin
    addr_d = addr_q;
    if (fire) begin
      addr_d = addr_q + (instr_compressed ? STEP_C : STEP_U);
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // On a simultaneous pop the new word lands one slot lower, behind the shift
  assign wr_idx = pop ? (count_q - CNT_W'(1)) : count_q;

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      word_d[i] = word_q[i];
      err_d[i]  = err_q[i];
    end
    if (pop) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        word_d[i] = word_q[i+1];
        err_d[i]  = err_q[i+1];
      end
    end
    if (push) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == wr_idx) begin
          word_d[i] = in_rdata_i;
          err_d[i]  = in_err_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      word_q[i] <= word_d[i];
    end
    err_q <= err_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      addr_q  <= '0;
    end else if (clear_i) begin
      count_q <= '0;
      addr_q  <= clear_addr_i & ~32'h1;
    end else begin
      count_q <= count_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_ibex_fetch_realign.sv
// tb/tb_ibex_fetch_realign.sv - self-checking bench for the fetch realigner
module tb_ibex_fetch_realign;

  localparam int DEPTH = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        clear_i;
  logic [31:0] clear_addr_i;
  logic        in_valid_i;
  logic [31:0] in_rdata_i;
  logic        in_err_i;
  logic        in_ready_o;
  logic        out_valid_o;
  logic [31:0] out_instr_o;
  logic [31:0] out_addr_o;
  logic        out_err_o;
  logic        out_ready_i;

  int checks = 0;
  int errors = 0;

  ibex_fetch_realign #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (clear_i),
    .clear_addr_i (clear_addr_i),
    .in_valid_i   (in_valid_i),
    .in_rdata_i   (in_rdata_i),
    .in_err_i     (in_err_i),
    .in_ready_o   (in_ready_o),
    .out_valid_o  (out_valid_o),
    .out_instr_o  (out_instr_o),
    .out_addr_o   (out_addr_o),
    .out_err_o    (out_err_o),
    .out_ready_i  (out_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: buffered words viewed as a stream of halfwords starting at the PC
  typedef struct packed {
    logic [31:0] w;
    logic        e;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_addr = 32'h0;
  bit          m_init = 1'b0;

  function automatic void model_eval(output bit v, output logic [31:0] ins,
                                     output logic [31:0] mask, output bit e,
                                     output bit comp, output bit pop);
    logic [15:0] hw[8];
    bit          he[8];
    int          s;
    int          avail;
    logic [15:0] h0;
    for (int k = 0; k < 8; k++) begin
      hw[k] = 16'h0;
      he[k] = 1'b0;
    end
    foreach (mq[k]) begin
      hw[2*k]   = mq[k].w[15:0];
      hw[2*k+1] = mq[k].w[31:16];
      he[2*k]   = mq[k].e;
      he[2*k+1] = mq[k].e;
    end
    s     = m_addr[1] ? 1 : 0;
    avail = 2 * mq.size() - s;
    v = 1'b0; ins = 32'h0; mask = 32'h0; e = 1'b0; comp = 1'b1; pop = 1'b0;
    if (avail >= 1) begin
      h0   = hw[s];
      comp = (h0[1:0] != 2'b11);
      if (comp) begin
        v = 1'b1; ins = {16'h0, h0}; mask = 32'h0000ffff; e = he[s];
      end else if (avail >= 2) begin
        v = 1'b1; ins = {hw[s+1], h0}; mask = 32'hffffffff; e = he[s] | he[s+1];
      end else begin
        v = he[s]; e = he[s]; ins = {16'h0, h0}; mask = 32'h0000ffff;
      end
      pop = (s + (comp ? 1 : 2)) >= 2;
    end
  endfunction

  always @(negedge clk_i) begin
    bit          v;
    bit          e;
    bit          comp;
    bit          pop;
    logic [31:0] ins;
    logic [31:0] mask;
    int          sz;
    model_eval(v, ins, mask, e, comp, pop);
    if (m_init) begin
      chk("m_valid", 32'(out_valid_o), 32'(v));
      chk("m_addr", out_addr_o, m_addr);
      chk("m_in_ready", 32'(in_ready_o), 32'((mq.size() < DEPTH) && !clear_i));
      if (v) begin
        chk("m_instr", out_instr_o & mask, ins & mask);
        chk("m_err", 32'(out_err_o), 32'(e));
      end
    end
    if (rst_i) begin
      mq.delete();
      m_addr = 32'h0;
      m_init = 1'b1;
    end else if (m_init) begin
      if (clear_i) begin
        mq.delete();
        m_addr = clear_addr_i & ~32'h1;
      end else begin
        sz = mq.size();
        if (v && out_ready_i) begin
          if (pop) void'(mq.pop_front());
          m_addr = m_addr + (comp ? 32'd2 : 32'd4);
        end
        if (in_valid_i && sz < DEPTH) mq.push_back('{w: in_rdata_i, e: in_err_i});
      end
    end
  end

  task automatic drive(input bit v, input logic [31:0] d, input bit er, input bit rdy,
                       input bit clr = 1'b0, input logic [31:0] ca = 32'h0,
                       input bit rst = 1'b0);
    @(posedge clk_i);
    #1;
    in_valid_i   = v;
    in_rdata_i   = d;
    in_err_i     = er;
    out_ready_i  = rdy;
    clear_i      = clr;
    clear_addr_i = ca;
    rst_i        = rst;
    @(negedge clk_i);
  endtask

  task automatic idle(input bit rdy);
    drive(1'b0, 32'h0, 1'b0, rdy);
  endtask

  task automatic push(input logic [31:0] d, input bit er, input bit rdy);
    drive(1'b1, d, er, rdy);
  endtask

  task automatic clr(input logic [31:0] ca);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, ca);
  endtask

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; clear_addr_i = 32'h0;
    in_valid_i = 1'b0; in_rdata_i = 32'h0; in_err_i = 1'b0; out_ready_i = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("rst_valid", 32'(out_valid_o), 32'h0);
    chk("rst_addr", out_addr_o, 32'h0);
    chk("rst_in_ready", 32'(in_ready_o), 32'h1);
    chk("rst_err", 32'(out_err_o), 32'h0);

    // Aligned mixed stream
    clr(32'h100);
    push(32'h0001_4501, 1'b0, 1'b0);
    chk("mix_empty_valid", 32'(out_valid_o), 32'h0);
    chk("mix_empty_addr", out_addr_o, 32'h100);
    push(32'h0000_0513, 1'b0, 1'b0);
    chk("mix_first_latency", 32'(out_valid_o), 32'h1);
    idle(1'b1);
    chk("mix_c0_instr", {16'h0, out_instr_o[15:0]}, 32'h4501);
    chk("mix_c0_addr", out_addr_o, 32'h100);
    idle(1'b1);
    chk("mix_c1_instr", {16'h0, out_instr_o[15:0]}, 32'h0001);
    chk("mix_c1_addr", out_addr_o, 32'h102);
    idle(1'b1);
    chk("mix_u_instr", out_instr_o, 32'h0000_0513);
    chk("mix_u_addr", out_addr_o, 32'h104);
    idle(1'b0);
    chk("mix_done_valid", 32'(out_valid_o), 32'h0);
    chk("mix_done_addr", out_addr_o, 32'h108);

    // Instruction spanning two words
    clr(32'h202);
    push(32'h0513_1234, 1'b0, 1'b1);
    push(32'hABCD_0000, 1'b0, 1'b1);
    chk("span_wait_valid", 32'(out_valid_o), 32'h0);
    idle(1'b0);
    chk("span_valid", 32'(out_valid_o), 32'h1);
    chk("span_instr", out_instr_o, 32'h0000_0513);
    chk("span_addr", out_addr_o, 32'h202);
    idle(1'b1);
    idle(1'b0);
    chk("span_pop_addr", out_addr_o, 32'h206);
    chk("span_pop_instr", {16'h0, out_instr_o[15:0]}, 32'hABCD);
    idle(1'b1);

    // Backpressure
    clr(32'h300);
    push(32'h1110_0013, 1'b0, 1'b0);
    push(32'h2220_0013, 1'b0, 1'b0);
    push(32'h3330_0013, 1'b0, 1'b0);
    push(32'h4440_0013, 1'b0, 1'b0);
    chk("bp_full_ready", 32'(in_ready_o), 32'h0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      chk("bp_hold_instr", out_instr_o, 32'h1110_0013);
      chk("bp_hold_ready", 32'(in_ready_o), 32'h0);
    end
    idle(1'b1);
    idle(1'b0);
    chk("bp_after_ready", 32'(in_ready_o), 32'h1);
    chk("bp_after_instr", out_instr_o, 32'h2220_0013);
    chk("bp_after_addr", out_addr_o, 32'h304);

    // Clear while words are buffered and a new word arrives
    clr(32'h400);
    push(32'h0000_0013, 1'b0, 1'b0);
    push(32'h0000_0093, 1'b0, 1'b0);
    drive(1'b1, 32'hDEAD_0013, 1'b0, 1'b1, 1'b1, 32'h1000);
    chk("clr_in_ready", 32'(in_ready_o), 32'h0);
    idle(1'b0);
    chk("clr_valid", 32'(out_valid_o), 32'h0);
    chk("clr_addr", out_addr_o, 32'h1000);
    idle(1'b0);
    chk("clr_dropped", 32'(out_valid_o), 32'h0);

    // Error propagation
    clr(32'h502);
    push(32'h0513_0000, 1'b1, 1'b0);
    idle(1'b0);
    chk("err_lo_valid", 32'(out_valid_o), 32'h1);
    chk("err_lo_err", 32'(out_err_o), 32'h1);
    idle(1'b1);
    idle(1'b0);
    chk("err_lo_next_addr", out_addr_o, 32'h506);
    clr(32'h602);
    push(32'h0513_0000, 1'b0, 1'b0);
    push(32'h0000_0000, 1'b1, 1'b0);
    idle(1'b0);
    chk("err_hi_err", 32'(out_err_o), 32'h1);
    chk("err_hi_instr", out_instr_o, 32'h0000_0513);
    idle(1'b1);
    idle(1'b1);

    // Reset overrides a simultaneous clear
    clr(32'h700);
    push(32'h0000_0013, 1'b0, 1'b0);
    push(32'h0000_0013, 1'b0, 1'b0);
    push(32'h0000_0013, 1'b0, 1'b0);
    idle(1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h900, 1'b1);
    idle(1'b0);
    chk("rstclr_addr", out_addr_o, 32'h0);
    chk("rstclr_valid", 32'(out_valid_o), 32'h0);
    chk("rstclr_ready", 32'(in_ready_o), 32'h1);

    // Mixed traffic checked against the model alone
    for (int i = 0; i < 300; i++) begin
      bit          c;
      logic [31:0] ca;
      c  = ($urandom_range(0, 19) == 0);
      ca = $urandom & 32'h0000_fffe;
      ca[0] = 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)), c, ca);
    end
    idle(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibex_fetch_realign.md
IBEX_FETCH_REALIGN -- requirements
Module: ibex_fetch_realign

Interface
REQ-001 SHALL have parameter DEPTH, default 3: number of 32-bit word entries buffered; legal values 2 to 4.
REQ-002 SHALL have port clk_i, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port clear_i, input, 1: flush all buffered words and load the fetch address; used on branch, jump or exception.
REQ-005 SHALL have port clear_addr_i, input, 32: new fetch address on clear; bit 0 is ignored.
REQ-006 SHALL have port in_valid_i, input, 1: memory response word valid.
REQ-007 SHALL have port in_rdata_i, input, 32: aligned instruction-memory word.
REQ-008 SHALL have port in_err_i, input, 1: bus error on this word.
REQ-009 SHALL have port in_ready_o, output, 1: a word can be accepted this cycle.
REQ-010 SHALL have port out_valid_o, output, 1: out_instr_o holds a complete raw instruction for the compressed decoder.
REQ-011 SHALL have port out_instr_o, output, 32: realigned raw instruction; for a compressed instruction bits [31:16] are don't-care.
REQ-012 SHALL have port out_addr_o, output, 32: halfword-aligned PC of out_instr_o.
REQ-013 SHALL have port out_err_o, output, 1: the instruction, or any part of it, came from an erroring word.
REQ-014 SHALL have port out_ready_i, input, 1: the consumer takes the instruction.

Function
REQ-015 SHALL hold a FIFO of DEPTH entries, each {32-bit word, err}, plus a count and a 32-bit instruction address register addr_q.
REQ-016 SHALL accept a word when in_valid_i & in_ready_o; in_ready_o = (count < DEPTH) & ~clear_i, with no same-cycle pop credit.
REQ-017 SHALL have 1-cycle latency: a word accepted in cycle N is visible at the outputs in cycle N+1; the outputs are combinational from the FIFO head and addr_q.
REQ-018 SHALL compute the outputs for aligned addr_q[1]=0: out_instr_o = e0 word; out_valid_o = e0 valid; out_err_o = e0.err.
REQ-019 SHALL compute the outputs for addr_q[1]=1 with a compressed instruction (e0[17:16] != 2'b11): out_instr_o = {16'b0, e0[31:16]}; out_valid_o = e0 valid; out_err_o = e0.err.
REQ-020 SHALL compute the outputs for addr_q[1]=1 with an uncompressed instruction: out_instr_o = {e1[15:0], e0[31:16]}; out_valid_o = e1 valid | (e0 valid & e0.err); out_err_o = e0.err | (e1 valid & e1.err).
REQ-021 SHALL set out_addr_o = addr_q at all times.
REQ-022 SHALL, on out_valid_o & out_ready_i, advance addr_q by 2 if the instruction is compressed, otherwise by 4, modulo 2^32.
REQ-023 SHALL, on out_valid_o & out_ready_i, pop e0 when the instruction ends at or past the word's upper halfword: addr_q[1]=1 (any size), or addr_q[1]=0 and uncompressed.
REQ-024 SHALL, on a simultaneous push and pop, perform both and leave count unchanged.
REQ-025 SHALL, in a cycle with clear_i=1, set count to 0, set addr_q to {clear_addr_i[31:1], 1'b0}, drop the input word, and ignore out_ready_i.
REQ-026 SHALL hold out_valid_o=0 while count=0, and while the upper half of a spanning instruction is missing and no error is present.
REQ-027 SHALL keep the instruction stable while out_valid_o=1 and out_ready_i=0, except across clear_i; the stall holds no matter how long out_ready_i stays low.

Reset
REQ-028 SHALL, while rst_i=1 at a clock edge, set count=0, addr_q=32'h0, in_ready_o=1 (after reset), out_valid_o=0, out_err_o=0; rst_i has priority over clear_i.
REQ-029 SHALL leave FIFO data contents unreset; out_instr_o is don't-care while out_valid_o=0.

Structure
REQ-030 SHALL add no new shared typedefs; DEPTH stays a module parameter, and the compressed test (bits[1:0] != 2'b11) is local logic.
REQ-031 SHALL implement storage inline as a shifting or circular register array, with no sub-module.
REQ-032 SHALL drive out_instr_o directly into the compressed-decoder input, and drive its valid input from out_valid_o.

Verification
REQ-033 SHALL cover aligned mixed stream: clear to 0x100; push 0x0001_4501, 0x0000_0513 -> outputs 0x4501 @0x100, 0x0001 @0x102, 0x00000513 @0x104.
REQ-034 SHALL cover a spanning instruction: clear to 0x202; push 0x0513_xxxx, then 0xxxxx_0000 -> out_valid_o=0 after the first push; 0x00000513 @0x202 after the second; e0 popped.
REQ-035 SHALL cover backpressure: fill DEPTH words with out_ready_i=0 -> in_ready_o=0, outputs stable; one pop of an aligned 32-bit instruction -> in_ready_o=1 the next cycle.
REQ-036 SHALL cover clear during activity: count=2, clear_i=1 with clear_addr_i=0x1000 and in_valid_i=1 -> next cycle count=0, out_valid_o=0, out_addr_o=0x1000, input word dropped.
REQ-037 SHALL cover error propagation: addr_q[1]=1, e0 uncompressed half with in_err_i=1 and no e1 -> out_valid_o=1, out_err_o=1; an e1-only error on a spanning instruction -> out_err_o=1.
REQ-038 SHALL cover reset mid-stream: rst_i=1 with count=3 and clear_i=1 -> count=0, out_addr_o=0x0, out_valid_o=0.
